// File: rtl/moving_sum_filter.sv
// Boxcar sum and average over the last 2^k accepted samples, with k selectable at run time.
// Define MOVING_SUM_DECIM_EN to assert valid_o only once per completed block of 2^k samples.
module moving_sum_filter #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MAX_LOG2 = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic signed [WIDTH-1:0]                data_i,
    input  logic                                   valid_i,
    input  logic        [$clog2(MAX_LOG2+1)-1:0]   win_log2_i,
    output logic signed [WIDTH-1:0]                data_o,
    output logic signed [WIDTH+MAX_LOG2-1:0]       sum_o,
    output logic                                   valid_o,
    output logic                                   full_o
);

    localparam int unsigned Depth = 1 << MAX_LOG2;
    localparam int unsigned SW    = WIDTH + MAX_LOG2;
    localparam int unsigned KW    = $clog2(MAX_LOG2 + 1);
    localparam int unsigned PW    = MAX_LOG2;
    localparam int unsigned FW    = MAX_LOG2 + 1;

    logic signed [WIDTH-1:0] buf_q [Depth];

    logic        [KW-1:0] win_q, win_d, k_eff;
    logic        [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr;
    logic        [FW-1:0] fill_q, fill_d, fill_nxt, win_len;
    logic signed [SW-1:0] sum_q, sum_d, sum_nxt, data_ext, old_ext;
    logic signed [WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d, full_q, full_d;
    logic                 win_change, accept, win_full, out_fire;

`ifdef MOVING_SUM_DECIM_EN
    logic [FW-1:0] dec_q, dec_d, dec_inc;
`endif

    always_comb begin
        k_eff      = (win_log2_i > KW'(MAX_LOG2)) ? KW'(MAX_LOG2) : win_log2_i;
        win_change = (k_eff != win_q);
        accept     = valid_i && !win_change;
        win_len    = FW'(1) << win_q;
        win_full   = (fill_q == win_len);
        // Oldest sample in the window sits 2^win_q slots behind the write pointer.
        rd_ptr     = wr_ptr_q - win_len[PW-1:0];
        data_ext   = {{MAX_LOG2{data_i[WIDTH-1]}}, data_i};
        old_ext    = win_full ? {{MAX_LOG2{buf_q[rd_ptr][WIDTH-1]}}, buf_q[rd_ptr]} : '0;
        sum_nxt    = sum_q + data_ext - old_ext;
        fill_nxt   = win_full ? fill_q : fill_q + FW'(1);
    end

`ifdef MOVING_SUM_DECIM_EN
    always_comb begin
        dec_inc  = dec_q + FW'(1);
        out_fire = (dec_inc == win_len);
        dec_d    = dec_q;
        if (win_change) begin
            dec_d = '0;
        end else if (accept) begin
            dec_d = out_fire ? '0 : dec_inc;
        end
    end
`else
    assign out_fire = 1'b1;
`endif

    always_comb begin
        win_d    = k_eff;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        sum_d    = sum_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        full_d   = full_q;
        if (win_change) begin
            fill_d = '0;
            sum_d  = '0;
            data_d = '0;
            full_d = 1'b0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            fill_d   = fill_nxt;
            sum_d    = sum_nxt;
            data_d   = WIDTH'(sum_nxt >>> win_q);
            valid_d  = out_fire;
            full_d   = (fill_nxt == win_len);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_q    <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            sum_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            win_q    <= win_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            sum_q    <= sum_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

`ifdef MOVING_SUM_DECIM_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end
`endif

    // Sample storage needs no reset: the fill count masks stale entries.
    always_ff @(posedge clk_i) begin
        if (!rst_i && accept) begin
            buf_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = data_q;
    assign sum_o   = sum_q;
    assign valid_o = valid_q;
    assign full_o  = full_q;

endmodule

// File: tb/tb_moving_sum_filter.sv
// Scoreboard bench for moving_sum_filter: a queue-of-samples reference model predicts each
// valid output; a negedge monitor pops and compares.
module tb_moving_sum_filter;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned MAX_LOG2 = 4;

    logic                         clk_i = 1'b0;
    logic                         rst_i = 1'b1;
    logic signed [WIDTH-1:0]      data_i = '0;
    logic                         valid_i = 1'b0;
    logic [2:0]                   win_log2_i = '0;
    logic signed [WIDTH-1:0]      data_o;
    logic signed [WIDTH+MAX_LOG2-1:0] sum_o;
    logic                         valid_o;
    logic                         full_o;

    moving_sum_filter #(.WIDTH(WIDTH), .MAX_LOG2(MAX_LOG2)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .win_log2_i (win_log2_i),
        .data_o     (data_o),
        .sum_o      (sum_o),
        .valid_o    (valid_o),
        .full_o     (full_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        longint sum;
        longint avg;
        bit     full;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad   = 0;

    // Reference model state: samples accepted since the last clear, and current window.
    int     hist[$];
    int     acc_cnt = 0;
    int     k_cur   = 0;

    function automatic void chk(string name, longint got, longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endfunction

    task automatic step(input bit r, input bit v, input int d, input int k);
        int     keff;
        int     n;
        int     lo;
        longint s;
        exp_t   e;
        rst_i      = r;
        valid_i    = v;
        data_i     = WIDTH'(d);
        win_log2_i = 3'(k);
        if (r) begin
            hist.delete();
            acc_cnt = 0;
            k_cur   = 0;
        end else begin
            keff = (k > MAX_LOG2) ? MAX_LOG2 : k;
            if (keff != k_cur) begin
                k_cur = keff;
                hist.delete();
                acc_cnt = 0;
            end else if (v) begin
                hist.push_back(d);
                if (hist.size() > (1 << MAX_LOG2)) void'(hist.pop_front());
                acc_cnt++;
                n  = 1 << k_cur;
                lo = (hist.size() > n) ? hist.size() - n : 0;
                s  = 0;
                for (int i = lo; i < hist.size(); i++) s += hist[i];
                e.sum  = s;
                e.avg  = longint'(shortint'(s >>> k_cur));
                e.full = (acc_cnt >= n);
`ifdef MOVING_SUM_DECIM_EN
                if (acc_cnt % n == 0) sb.push_back(e);
`else
                sb.push_back(e);
`endif
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (valid_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got valid_o=1 expected no output at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("sum_o", longint'(sum_o), e.sum);
                chk("data_o", longint'(data_o), e.avg);
                chk("full_o", longint'(full_o), longint'(e.full));
            end
        end
    end

    task automatic chk_zero(string tag);
        chk({tag, "_sum"}, longint'(sum_o), 0);
        chk({tag, "_data"}, longint'(data_o), 0);
        chk({tag, "_valid"}, longint'(valid_o), 0);
        chk({tag, "_full"}, longint'(full_o), 0);
    endtask

    initial begin
        logic [15:0] r16;
        int d;
        int k;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk_zero("reset");

        // Fill and slide, k=2
        step(0, 0, 0, 2);
        for (int i = 1; i <= 5; i++) step(0, 1, 4 * i, 2);

        // Negative floor, k=1
        step(0, 0, 0, 1);
        step(0, 1, -3, 1);
        step(0, 1, -4, 1);
        step(0, 1, -5, 1);

        // Extremes, k=4
        step(0, 0, 0, 4);
        for (int i = 0; i < 16; i++) step(0, 1, 32767, 4);
        for (int i = 0; i < 16; i++) step(0, 1, -32768, 4);

        // Gaps hold the sum
        step(0, 0, 0, 2);
        step(0, 1, 1, 2);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 99, 2);
            chk("gap_hold_sum", longint'(sum_o), 1);
            chk("gap_valid", longint'(valid_o), 0);
        end
        step(0, 1, 2, 2);
        // Window change drops the presented sample and clears state
        step(0, 1, 9, 3);
        chk_zero("winchg");
        step(0, 1, 5, 3);
        step(0, 1, 6, 7);
        chk_zero("clamp");
        for (int i = 0; i < 18; i++) step(0, 1, i * 100 - 700, 7);
        step(0, 1, 3, 4);
        chk("clamp_no_change_valid", longint'(valid_o), 1);

        // Reset mid-operation
        step(0, 0, 0, 2);
        step(0, 1, 10, 2);
        step(0, 1, 20, 2);
        step(0, 1, 30, 2);
        step(1, 1, 40, 2);
        chk_zero("midreset");
        step(0, 0, 0, 2);
        step(0, 1, 7, 2);
        chk("post_reset_sum", longint'(sum_o), 7);
        chk("post_reset_full", longint'(full_o), 0);

        // Decimated block average, k=2, inputs 1..8
        step(0, 0, 0, 2);
        for (int i = 1; i <= 8; i++) step(0, 1, i, 2);

        // Randomized traffic
        k = 2;
        for (int i = 0; i < 3000; i++) begin
            r16 = 16'($urandom);
            case ($urandom_range(0, 9))
                0: d = 32767;
                1: d = -32768;
                default: d = int'($signed(r16));
            endcase
            if ($urandom_range(0, 59) == 0) k = $urandom_range(0, 7);
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7), d, k);
        end

        step(0, 0, 0, k);
        step(0, 0, 0, k);
        chk("scoreboard_drained", longint'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
